led_frame_buffer: RTL and testbench
===================================

Name: led_frame_buffer

Overview:
- Double-buffered 16x16 two-colour pixel store. It sits directly upstream of the 16x16x2 LED display driver and produces its RedPixels/GrnPixels arrays.
- Game logic draws into the back bank using pixel writes or row writes. A swap request presents the back bank; the swap is taken only at the display scan wrap, so frames never tear.
- A bank-clear sequencer and an optional front-to-back copy sequencer support incremental drawing.

Parameters:
- SYNC_SWAP, 1: 1 = a pending swap waits for scan_wrap; 0 = the swap executes on the cycle after the request.
- COPY_ON_SWAP, 0: 1 = after each swap, copy the new front bank into the new back bank (16 cycles).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  single-pixel write strobe
- wr_row  in  4  pixel row index
- wr_col  in  4  pixel column index
- wr_color  in  2  colour code: bit0 = red, bit1 = green (00 = off, 11 = both)
- row_wr_en  in  1  whole-row write strobe
- row_wr_row  in  4  row index for the row write
- row_wr_red  in  16  red bits, bit c = column c
- row_wr_grn  in  16  green bits, bit c = column c
- clear_req  in  1  fill the back bank with clear_color
- clear_color  in  2  fill colour, latched on an accepted clear_req
- swap_req  in  1  request a front/back bank exchange
- scan_wrap  in  1  one-cycle pulse when the display row scan wraps from 15 to 0
- RedPixels  out  [15:0][15:0]  front bank red plane, indexed [row][col]
- GrnPixels  out  [15:0][15:0]  front bank green plane, indexed [row][col]
- busy  out  1  high in every state except IDLE
- swap_done  out  1  one-cycle pulse on the cycle the outputs take the new front bank
- frame_count  out  8  number of completed swaps, wraps 255 -> 0

Behaviour:
- Reset: both banks all zero; front select = bank 0; state = IDLE; RedPixels/GrnPixels = 0; busy = 0; swap_done = 0; frame_count = 0. Reset overrides any operation in progress; pending requests are discarded.
- States: IDLE, CLEAR, WAIT_SWAP, COPY.
- IDLE:
  - An accepted clear_req goes to CLEAR with row counter 0.
  - Otherwise an accepted swap_req goes to WAIT_SWAP.
  - clear_req has priority over swap_req when both arrive in the same cycle; the swap_req is dropped.
- CLEAR: one back-bank row per cycle, rows 0..15, all set to the latched clear_color. Lasts exactly 16 cycles, then returns to IDLE.
- WAIT_SWAP:
  - SYNC_SWAP = 1: the swap executes in the cycle scan_wrap = 1. If scan_wrap is high on the same cycle swap_req is accepted, the swap still waits for the next scan_wrap.
  - SYNC_SWAP = 0: the swap executes on the first WAIT_SWAP cycle.
  - On the swap edge: toggle front select, frame_count += 1, and register the outputs from the new front bank.
  - On the following cycle: swap_done = 1 and the outputs show the new frame.
  - Next state is COPY if COPY_ON_SWAP = 1, otherwise IDLE.
- COPY: one row per cycle, front row r copied to back row r, r = 0..15. Lasts 16 cycles, then IDLE.
- Writes:
  - Accepted only in IDLE; writes arriving while busy are dropped silently.
  - Writes always target the back bank and never change the outputs until a swap.
  - If wr_en and row_wr_en arrive in the same cycle, the row write applies first and the pixel write overlays its single pixel. The pixel wins on a coincident (row, col).
- Requests (clear_req, swap_req) arriving while busy are dropped; they are not queued.
- Outputs are registered and change only on the swap edge and at reset.
- Index range: all indices are 4-bit, so every value is legal and no bounds check is needed.

Decomposition:
- Package led_fb_pkg:
  - ROWS = 16, COLS = 16
  - colour_t: 2-bit enum OFF / RED / GRN / BOTH
  - fb_state_t: enum IDLE / CLEAR / WAIT_SWAP / COPY
  - plane_t: [15:0][15:0] logic
- Sub-module fb_bank: one red plane and one green plane, with one row-write port (row index, red/grn row data, enable) and one pixel-write overlay port. Instantiated twice. The top level holds the FSM, counters, front select and output registers.

Test Plan:
- Reset, then write pixel (2,3) = BOTH and swap_req with SYNC_SWAP = 1, scan_wrap pulsed 5 cycles later -> outputs stay 0 until the swap edge; the next cycle has RedPixels[2][3] = GrnPixels[2][3] = 1, swap_done = 1 for exactly one cycle, frame_count = 1.
- clear_req with clear_color = RED, then wr_en on cycles 1..15 of CLEAR -> busy = 1 for exactly 16 cycles and all writes dropped; after a swap, RedPixels = all ones and GrnPixels = all zeros.
- Same-cycle row write to row 4 (red = 16'hFFFF, grn = 0) and pixel write (4,7) = GRN, then swap -> RedPixels[4] = 16'hFF7F, GrnPixels[4] = 16'h0080.
- Same-cycle clear_req and swap_req in IDLE -> only CLEAR runs; frame_count is unchanged after 40 cycles with scan_wrap pulsing.
- COPY_ON_SWAP = 1: draw pixel (0,0) = RED, then swap -> busy for 16 cycles after swap_done; write (1,1) = GRN and swap -> the front bank shows both pixels.
- Assert reset mid-CLEAR (cycle 8) -> the next cycle has every output 0, busy = 0, and both banks read back 0 after a swap.

Source files
------------

// File: rtl/led_fb_pkg.sv
// led_fb_pkg: shared sizes, colour/state enums and plane type for the LED frame buffer
package led_fb_pkg;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  typedef enum logic [1:0] {OFF, RED, GRN, BOTH} colour_t;
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP, COPY} fb_state_t;
  typedef logic [ROWS-1:0][COLS-1:0] plane_t;
endpackage

// File: rtl/led_frame_buffer_bank.sv
// fb_bank: one red/green pixel plane pair with a row-write port and a pixel-write overlay
module fb_bank
  import led_fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        row_en,
  input  logic [3:0]  row_idx,
  input  logic [15:0] row_red,
  input  logic [15:0] row_grn,
  input  logic        px_en,
  input  logic [3:0]  px_row,
  input  logic [3:0]  px_col,
  input  logic [1:0]  px_color,
  output plane_t      red,
  output plane_t      grn
);
  always_ff @(posedge clk) begin
    if (reset) begin
      red <= '0;
      grn <= '0;
    end else begin
      if (row_en) begin
        red[row_idx] <= row_red;
        grn[row_idx] <= row_grn;
      end
      if (px_en) begin
        red[px_row][px_col] <= px_color[0];
        grn[px_row][px_col] <= px_color[1];
      end
    end
  end
endmodule

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered 16x16 two-colour pixel store with tear-free swap, clear and copy
module led_frame_buffer
  import led_fb_pkg::*;
#(
  parameter bit SYNC_SWAP    = 1'b1,
  parameter bit COPY_ON_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_row,
  input  logic [3:0]  wr_col,
  input  logic [1:0]  wr_color,
  input  logic        row_wr_en,
  input  logic [3:0]  row_wr_row,
  input  logic [15:0] row_wr_red,
  input  logic [15:0] row_wr_grn,
  input  logic        clear_req,
  input  logic [1:0]  clear_color,
  input  logic        swap_req,
  input  logic        scan_wrap,
  output plane_t      RedPixels,
  output plane_t      GrnPixels,
  output logic        busy,
  output logic        swap_done,
  output logic [7:0]  frame_count
);
  fb_state_t   state;
  logic [3:0]  cnt;
  colour_t     clr;
  logic        front;
  plane_t      red0, grn0, red1, grn1;
  plane_t      front_red, front_grn, back_red, back_grn;
  logic        idle, row_en, px_en, go;
  logic [3:0]  row_idx;
  logic [15:0] row_red, row_grn;
  assign idle      = state == IDLE;
  assign busy      = !idle;
  assign front_red = front ? red1 : red0;
  assign front_grn = front ? grn1 : grn0;
  assign back_red  = front ? red0 : red1;
  assign back_grn  = front ? grn0 : grn1;
  assign row_en    = (idle && row_wr_en) || state == CLEAR || state == COPY;
  assign px_en     = idle && wr_en;
  assign row_idx   = idle ? row_wr_row : cnt;
  assign row_red   = idle ? row_wr_red : state == CLEAR ? {16{clr[0]}} : front_red[cnt];
  assign row_grn   = idle ? row_wr_grn : state == CLEAR ? {16{clr[1]}} : front_grn[cnt];
  assign go        = state == WAIT_SWAP && (!SYNC_SWAP || scan_wrap);
  fb_bank u_bank0 (
    .clk(clk), .reset(reset),
    .row_en(row_en && front), .row_idx(row_idx), .row_red(row_red), .row_grn(row_grn),
    .px_en(px_en && front), .px_row(wr_row), .px_col(wr_col), .px_color(wr_color),
    .red(red0), .grn(grn0)
  );
  fb_bank u_bank1 (
    .clk(clk), .reset(reset),
    .row_en(row_en && !front), .row_idx(row_idx), .row_red(row_red), .row_grn(row_grn),
    .px_en(px_en && !front), .px_row(wr_row), .px_col(wr_col), .px_color(wr_color),
    .red(red1), .grn(grn1)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      clr         <= OFF;
      front       <= 1'b0;
      RedPixels   <= '0;
      GrnPixels   <= '0;
      swap_done   <= 1'b0;
      frame_count <= '0;
    end else begin
      swap_done <= go;
      if (go) begin
        front       <= !front;
        frame_count <= frame_count + 8'd1;
        RedPixels   <= back_red;
        GrnPixels   <= back_grn;
      end
      case (state)
        IDLE:
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
            clr   <= colour_t'(clear_color);
          end else if (swap_req) begin
            state <= WAIT_SWAP;
          end
        CLEAR, COPY: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= IDLE;
        end
        WAIT_SWAP:
          if (go) begin
            state <= COPY_ON_SWAP ? COPY : IDLE;
            cnt   <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer: scoreboard bench for the double-buffered LED frame buffer
module tb_led_frame_buffer;
  import led_fb_pkg::*;
  typedef struct {
    plane_t     r;
    plane_t     g;
    logic [7:0] fc;
  } frame_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        wr_en = 1'b0, row_wr_en = 1'b0, clear_req = 1'b0, swap_req = 1'b0, scan_wrap = 1'b0;
  logic [3:0]  wr_row = '0, wr_col = '0, row_wr_row = '0;
  logic [1:0]  wr_color = '0, clear_color = '0;
  logic [15:0] row_wr_red = '0, row_wr_grn = '0;
  plane_t      red, grn, red2, grn2;
  logic        busy, swap_done, busy2, swap_done2;
  logic [7:0]  frame_count, frame_count2;
  int          checks = 0, errors = 0;
  plane_t      mb_r, mb_g, mf_r, mf_g;
  logic [7:0]  mfc;
  frame_t      sb[$];
  led_frame_buffer dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color),
    .row_wr_en(row_wr_en), .row_wr_row(row_wr_row), .row_wr_red(row_wr_red), .row_wr_grn(row_wr_grn),
    .clear_req(clear_req), .clear_color(clear_color), .swap_req(swap_req), .scan_wrap(scan_wrap),
    .RedPixels(red), .GrnPixels(grn), .busy(busy), .swap_done(swap_done), .frame_count(frame_count)
  );
  led_frame_buffer #(.SYNC_SWAP(1'b0), .COPY_ON_SWAP(1'b1)) dut_copy (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color),
    .row_wr_en(row_wr_en), .row_wr_row(row_wr_row), .row_wr_red(row_wr_red), .row_wr_grn(row_wr_grn),
    .clear_req(clear_req), .clear_color(clear_color), .swap_req(swap_req), .scan_wrap(scan_wrap),
    .RedPixels(red2), .GrnPixels(grn2), .busy(busy2), .swap_done(swap_done2), .frame_count(frame_count2)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    mb_r = '0; mb_g = '0; mf_r = '0; mf_g = '0; mfc = '0;
    sb.delete();
  endtask
  task automatic draw(input logic pe, input logic [3:0] pr, input logic [3:0] pc, input logic [1:0] pcol,
                      input logic re, input logic [3:0] rr, input logic [15:0] rred, input logic [15:0] rgrn);
    wr_en = pe; wr_row = pr; wr_col = pc; wr_color = pcol;
    row_wr_en = re; row_wr_row = rr; row_wr_red = rred; row_wr_grn = rgrn;
    if (re) begin
      mb_r[rr] = rred;
      mb_g[rr] = rgrn;
    end
    if (pe) begin
      mb_r[pr][pc] = pcol[0];
      mb_g[pr][pc] = pcol[1];
    end
    tick;
    wr_en = 1'b0;
    row_wr_en = 1'b0;
  endtask
  task automatic run_swap(input int delay, input bit wrap_at_req);
    frame_t e;
    plane_t pr, pg;
    pr = mf_r;
    pg = mf_g;
    swap_req = 1'b1;
    scan_wrap = wrap_at_req;
    tick;
    swap_req = 1'b0;
    scan_wrap = 1'b0;
    mfc = mfc + 8'd1;
    e.r = mb_r; e.g = mb_g; e.fc = mfc;
    sb.push_back(e);
    {mf_r, mb_r} = {mb_r, mf_r};
    {mf_g, mb_g} = {mb_g, mf_g};
    for (int i = 0; i < delay; i++) begin
      checks++;
      if (red !== pr || grn !== pg || swap_done !== 1'b0) begin
        errors++;
        $display("FAIL hold_before_wrap red=%h grn=%h done=%b expected red=%h grn=%h done=0", red, grn, swap_done, pr, pg);
      end
      tick;
    end
    scan_wrap = 1'b1;
    tick;
    scan_wrap = 1'b0;
    e = sb.pop_front();
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL swap_done_after_wrap got %b expected 1", swap_done);
    end
    checks++;
    if (red !== e.r) begin
      errors++;
      $display("FAIL sb_red got %h expected %h", red, e.r);
    end
    checks++;
    if (grn !== e.g) begin
      errors++;
      $display("FAIL sb_grn got %h expected %h", grn, e.g);
    end
    checks++;
    if (frame_count !== e.fc) begin
      errors++;
      $display("FAIL sb_frame_count got %0d expected %0d", frame_count, e.fc);
    end
    tick;
    checks++;
    if (swap_done !== 1'b0) begin
      errors++;
      $display("FAIL swap_done_one_cycle got %b expected 0", swap_done);
    end
  endtask
  task automatic test_reset;
    do_reset;
    checks++;
    if (red !== '0 || grn !== '0) begin
      errors++;
      $display("FAIL reset_pixels red=%h grn=%h expected 0", red, grn);
    end
    checks++;
    if (busy !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, swap_done);
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame_count got %0d expected 0", frame_count);
    end
  endtask
  task automatic test_pixel_swap;
    draw(1'b1, 4'd2, 4'd3, 2'd3, 1'b0, 4'd0, 16'h0, 16'h0);
    run_swap(5, 1'b0);
    checks++;
    if (red[2][3] !== 1'b1 || grn[2][3] !== 1'b1 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL pixel_2_3 r=%b g=%b fc=%0d expected 1 1 1", red[2][3], grn[2][3], frame_count);
    end
  endtask
  task automatic test_wrap_same_cycle;
    draw(1'b1, 4'd9, 4'd14, 2'd1, 1'b0, 4'd0, 16'h0, 16'h0);
    run_swap(3, 1'b1);
  endtask
  task automatic test_clear_busy;
    int n = 0;
    clear_req = 1'b1;
    clear_color = 2'd1;
    tick;
    clear_req = 1'b0;
    mb_r = '1;
    mb_g = '0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin
        n++;
        wr_en = 1'b1;
        wr_row = 4'($urandom);
        wr_col = 4'($urandom);
        wr_color = 2'd2;
      end else begin
        wr_en = 1'b0;
      end
      tick;
    end
    wr_en = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d expected 16", n);
    end
    run_swap(1, 1'b0);
    checks++;
    if (red !== '1 || grn !== '0) begin
      errors++;
      $display("FAIL clear_red_fill red=%h grn=%h expected all ones / zero", red, grn);
    end
  endtask
  task automatic test_row_pixel;
    draw(1'b1, 4'd4, 4'd7, 2'd2, 1'b1, 4'd4, 16'hFFFF, 16'h0000);
    run_swap(2, 1'b0);
    checks++;
    if (red[4] !== 16'hFF7F || grn[4] !== 16'h0080) begin
      errors++;
      $display("FAIL row_pixel_overlay red=%h grn=%h expected ff7f 0080", red[4], grn[4]);
    end
  endtask
  task automatic test_clear_swap_same;
    logic seen = 1'b0;
    clear_req = 1'b1;
    swap_req = 1'b1;
    clear_color = 2'd0;
    tick;
    clear_req = 1'b0;
    swap_req = 1'b0;
    mb_r = '0;
    mb_g = '0;
    for (int i = 0; i < 40; i++) begin
      scan_wrap = (i % 8 == 3);
      seen |= swap_done;
      tick;
    end
    scan_wrap = 1'b0;
    checks++;
    if (seen !== 1'b0 || frame_count !== mfc || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_swap done_seen=%b fc=%0d busy=%b expected 0 %0d 0", seen, frame_count, busy, mfc);
    end
    run_swap(1, 1'b0);
  endtask
  task automatic test_random_draw;
    for (int i = 0; i < 24; i++)
      draw(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 16'($urandom));
    run_swap(2, 1'b0);
  endtask
  task automatic test_frame_wrap;
    for (int i = 0; i < 256; i++) run_swap(1, 1'b0);
  endtask
  task automatic test_reset_mid_clear;
    clear_req = 1'b1;
    clear_color = 2'd3;
    tick;
    clear_req = 1'b0;
    repeat (7) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (red !== '0 || grn !== '0 || busy !== 1'b0 || swap_done !== 1'b0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_clear red=%h grn=%h busy=%b done=%b fc=%0d expected all 0", red, grn, busy, swap_done, frame_count);
    end
    mb_r = '0; mb_g = '0; mf_r = '0; mf_g = '0; mfc = '0;
    sb.delete();
    run_swap(2, 1'b0);
    run_swap(2, 1'b0);
  endtask
  task automatic test_copy_on_swap;
    int n = 0;
    plane_t er = '0, eg = '0;
    er[0][0] = 1'b1;
    eg[1][1] = 1'b1;
    do_reset;
    draw(1'b1, 4'd0, 4'd0, 2'd1, 1'b0, 4'd0, 16'h0, 16'h0);
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    tick;
    checks++;
    if (swap_done2 !== 1'b1 || red2[0][0] !== 1'b1 || frame_count2 !== 8'd1) begin
      errors++;
      $display("FAIL copy_first_swap done=%b r00=%b fc=%0d expected 1 1 1", swap_done2, red2[0][0], frame_count2);
    end
    while (busy2 && n < 40) begin
      n++;
      tick;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL copy_busy_cycles got %0d expected 16", n);
    end
    draw(1'b1, 4'd1, 4'd1, 2'd2, 1'b0, 4'd0, 16'h0, 16'h0);
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    tick;
    checks++;
    if (swap_done2 !== 1'b1 || red2 !== er || grn2 !== eg || frame_count2 !== 8'd2) begin
      errors++;
      $display("FAIL copy_second_swap done=%b red=%h grn=%h fc=%0d expected 1 %h %h 2", swap_done2, red2, grn2, frame_count2, er, eg);
    end
  endtask
  initial begin
    test_reset;
    test_pixel_swap;
    test_wrap_same_cycle;
    test_clear_busy;
    test_row_pixel;
    test_clear_swap_same;
    test_random_draw;
    test_frame_wrap;
    test_reset_mid_clear;
    test_copy_on_swap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
